// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer
// Control sequencer for a 4-bank rotating line buffer. It tracks the incoming
// pixel coordinates and produces per-pixel bank write strobes/addresses, rotates
// the write bank at each line end and drives the three read-tap bank selects.
// It also reports frame-aligned fill status and the row held on the centre tap.
// It stores no pixel data itself.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   hcount_in         column of incoming pixel
//   vcount_in         row of incoming pixel
//   data_valid_in     incoming pixel valid
//   wr_en_out         write strobe to the selected bank
//   wr_bank_out       one-hot write bank select
//   wr_addr_out       bank write address (hcount_in[8:0])
//   rd_sel_out        bank index per read tap; [0] newest complete line
//   lines_filled_out  complete lines in the current frame, saturating at 3
//   window_valid_out  three complete lines of the current frame are buffered
//   center_row_out    vcount of the line on tap [1]
//   line_done_out     pulse: a line just completed
//   frame_done_out    pulse: the last line of the frame just completed
//   sync_err_out      pulse: frame restart seen mid-frame
//   range_err_out     sticky: valid pixel outside the active area seen
module line_buffer_sequencer #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [10:0]     hcount_in,
    input  logic [9:0]      vcount_in,
    input  logic            data_valid_in,
    output logic            wr_en_out,
    output logic [3:0]      wr_bank_out,
    output logic [8:0]      wr_addr_out,
    output logic [2:0][1:0] rd_sel_out,
    output logic [1:0]      lines_filled_out,
    output logic            window_valid_out,
    output logic [9:0]      center_row_out,
    output logic            line_done_out,
    output logic            frame_done_out,
    output logic            sync_err_out,
    output logic            range_err_out
);

    localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LIMIT = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      wr_idx_q, wr_idx_d;
    logic            wr_en_q, wr_en_d;
    logic [3:0]      wr_bank_q, wr_bank_d;
    logic [8:0]      wr_addr_q, wr_addr_d;
    logic [2:0][1:0] rd_sel_q, rd_sel_d;
    logic [1:0]      lines_q, lines_d;
    logic            window_valid_q, window_valid_d;
    logic [9:0]      center_row_q, center_row_d;
    logic            line_done_q, line_done_d;
    logic            frame_done_q, frame_done_d;
    logic            sync_err_q, sync_err_d;
    logic            range_err_q, range_err_d;

    logic            in_range_s;
    logic            frame_start_s;
    logic            accept_s;
    logic            line_end_s;
    logic            frame_end_s;
    logic [1:0]      lines_base_s;
    logic [1:0]      lines_next_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0001;
        endcase
        return res;
    endfunction

    // Pixel classification shared by the next-state and output logic.
    always_comb begin
        in_range_s    = (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT);
        frame_start_s = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        // IDLE only lets a frame start through; out-of-range pixels are never written.
        accept_s      = data_valid_in && in_range_s && ((state_q != ST_IDLE) || frame_start_s);
        line_end_s    = accept_s && (hcount_in == H_LAST);
        frame_end_s   = line_end_s && (vcount_in == V_LAST);
        // A frame start (fresh or restart) clears the fill count before this pixel counts.
        if (frame_start_s) begin
            lines_base_s = 2'd0;
        end else begin
            lines_base_s = lines_q;
        end
        if (line_end_s && (lines_base_s != 2'd3)) begin
            lines_next_s = lines_base_s + 2'd1;
        end else begin
            lines_next_s = lines_base_s;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the last line of a frame always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_end_s) begin
                    state_d = ST_IDLE;
                end else if (frame_start_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL, ST_STREAM: begin
                if (frame_end_s) begin
                    state_d = ST_IDLE;
                end else if (frame_start_s) begin
                    state_d = ST_FILL;
                end else if (lines_next_s == 2'd3) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything is registered below.
    always_comb begin
        wr_en_d      = accept_s;
        line_done_d  = line_end_s;
        frame_done_d = frame_end_s;
        // A mid-frame frame start restarts the fill without rotating the bank.
        sync_err_d   = frame_start_s && (state_q != ST_IDLE);
        range_err_d  = range_err_q || (data_valid_in && !in_range_s);
        lines_d      = lines_next_s;
        if (accept_s) begin
            wr_addr_d = hcount_in[8:0];
            wr_bank_d = onehot4(wr_idx_q);
        end else begin
            wr_addr_d = wr_addr_q;
            wr_bank_d = wr_bank_q;
        end
        if (line_end_s) begin
            wr_idx_d = wr_idx_q + 2'd1;
            if (vcount_in == 10'd0) begin
                center_row_d = 10'd0;
            end else begin
                center_row_d = vcount_in - 10'd1;
            end
        end else begin
            wr_idx_d     = wr_idx_q;
            center_row_d = center_row_q;
        end
        if (line_end_s && (lines_next_s == 2'd3)) begin
            window_valid_d = 1'b1;
        end else if (frame_start_s) begin
            window_valid_d = 1'b0;
        end else begin
            window_valid_d = window_valid_q;
        end
        rd_sel_d[0] = wr_idx_d - 2'd1;
        rd_sel_d[1] = wr_idx_d - 2'd2;
        rd_sel_d[2] = wr_idx_d - 2'd3;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_idx_q       <= 2'd0;
            wr_en_q        <= 1'b0;
            wr_bank_q      <= 4'b0001;
            wr_addr_q      <= 9'd0;
            rd_sel_q       <= {2'd1, 2'd2, 2'd3};
            lines_q        <= 2'd0;
            window_valid_q <= 1'b0;
            center_row_q   <= 10'd0;
            line_done_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            sync_err_q     <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            wr_idx_q       <= wr_idx_d;
            wr_en_q        <= wr_en_d;
            wr_bank_q      <= wr_bank_d;
            wr_addr_q      <= wr_addr_d;
            rd_sel_q       <= rd_sel_d;
            lines_q        <= lines_d;
            window_valid_q <= window_valid_d;
            center_row_q   <= center_row_d;
            line_done_q    <= line_done_d;
            frame_done_q   <= frame_done_d;
            sync_err_q     <= sync_err_d;
            range_err_q    <= range_err_d;
        end
    end

    assign wr_en_out        = wr_en_q;
    assign wr_bank_out      = wr_bank_q;
    assign wr_addr_out      = wr_addr_q;
    assign rd_sel_out       = rd_sel_q;
    assign lines_filled_out = lines_q;
    assign window_valid_out = window_valid_q;
    assign center_row_out   = center_row_q;
    assign line_done_out    = line_done_q;
    assign frame_done_out   = frame_done_q;
    assign sync_err_out     = sync_err_q;
    assign range_err_out    = range_err_q;

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Directed bench for line_buffer_sequencer with an 8x6 active area.
module tb_line_buffer_sequencer;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [10:0]     hcount_in = 11'd0;
    logic [9:0]      vcount_in = 10'd0;
    logic            data_valid_in = 1'b0;
    logic            wr_en_out;
    logic [3:0]      wr_bank_out;
    logic [8:0]      wr_addr_out;
    logic [2:0][1:0] rd_sel_out;
    logic [1:0]      lines_filled_out;
    logic            window_valid_out;
    logic [9:0]      center_row_out;
    logic            line_done_out;
    logic            frame_done_out;
    logic            sync_err_out;
    logic            range_err_out;

    int checks = 0;
    int errors = 0;
    // Reference model state
    int bidx = 0;
    int exp_lines = 0;
    int exp_wv = 0;
    int exp_center = 0;
    int exp_rerr = 0;
    int ld_cnt = 0;
    int wen_cnt = 0;

    line_buffer_sequencer #(.H_ACTIVE(8), .V_ACTIVE(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_in(data_valid_in), .wr_en_out(wr_en_out), .wr_bank_out(wr_bank_out),
        .wr_addr_out(wr_addr_out), .rd_sel_out(rd_sel_out), .lines_filled_out(lines_filled_out),
        .window_valid_out(window_valid_out), .center_row_out(center_row_out),
        .line_done_out(line_done_out), .frame_done_out(frame_done_out),
        .sync_err_out(sync_err_out), .range_err_out(range_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then settle just after the edge.
    task automatic step(input logic v, input int h, input int vv);
        data_valid_in = v;
        hcount_in = 11'(h);
        vcount_in = 10'(vv);
        @(posedge clk_in);
        #1;
    endtask

    function automatic int exp_rd(input int idx);
        return (((idx + 1) % 4) << 4) | (((idx + 2) % 4) << 2) | ((idx + 3) % 4);
    endfunction

    // Send an in-range pixel expected to be accepted and check every output.
    task automatic send_pix(input int h, input int v);
        int bank;
        step(1'b1, h, v);
        bank = 1 << bidx;
        wen_cnt += int'(wr_en_out);
        ld_cnt  += int'(line_done_out);
        if (h == 7) begin
            bidx = (bidx + 1) % 4;
            if (exp_lines < 3) exp_lines++;
            if (exp_lines == 3) exp_wv = 1;
            exp_center = (v == 0) ? 0 : v - 1;
        end
        chk("wr_en", 32'(wr_en_out), 32'd1);
        chk("wr_addr", 32'(wr_addr_out), 32'(h));
        chk("wr_bank", 32'(wr_bank_out), 32'(bank));
        chk("line_done", 32'(line_done_out), 32'(h == 7));
        chk("frame_done", 32'(frame_done_out), 32'(h == 7 && v == 5));
        chk("rd_sel", 32'(rd_sel_out), 32'(exp_rd(bidx)));
        chk("lines_filled", 32'(lines_filled_out), 32'(exp_lines));
        chk("window_valid", 32'(window_valid_out), 32'(exp_wv));
        chk("center_row", 32'(center_row_out), 32'(exp_center));
        chk("sync_err", 32'(sync_err_out), 32'd0);
        chk("range_err", 32'(range_err_out), 32'(exp_rerr));
    endtask

    // Full frame from (0,0); optional random idle cycles between pixels.
    task automatic run_frame(input bit gaps);
        exp_lines = 0;
        exp_wv = 0;
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 8; h++) begin
                if (gaps && ($urandom_range(0, 2) == 0)) begin
                    step(1'b0, 7, 5);
                    wen_cnt += int'(wr_en_out);
                    chk("gap_wr_en", 32'(wr_en_out), 32'd0);
                    chk("gap_line_done", 32'(line_done_out), 32'd0);
                end
                send_pix(h, v);
            end
        end
    endtask

    initial begin
        // Reset values
        rst_in = 1'b1;
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        chk("rst_wr_en", 32'(wr_en_out), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank_out), 32'h1);
        chk("rst_wr_addr", 32'(wr_addr_out), 32'd0);
        chk("rst_rd_sel", 32'(rd_sel_out), 32'h1B);
        chk("rst_lines", 32'(lines_filled_out), 32'd0);
        chk("rst_wv", 32'(window_valid_out), 32'd0);
        chk("rst_center", 32'(center_row_out), 32'd0);
        chk("rst_pulses", 32'({line_done_out, frame_done_out, sync_err_out}), 32'd0);
        chk("rst_range_err", 32'(range_err_out), 32'd0);
        rst_in = 1'b0;

        // Pixels before any frame start are ignored
        step(1'b1, 3, 2);
        chk("idle_wr_en", 32'(wr_en_out), 32'd0);
        step(1'b1, 7, 2);
        chk("idle_wr_en_end", 32'(wr_en_out), 32'd0);
        chk("idle_line_done", 32'(line_done_out), 32'd0);

        // Frame 1, gapless
        ld_cnt = 0;
        run_frame(1'b0);
        chk("f1_line_done_count", 32'(ld_cnt), 32'd6);

        // Window stays readable in IDLE; non-start pixels still ignored
        step(1'b0, 0, 0);
        chk("hold_wv", 32'(window_valid_out), 32'd1);
        chk("hold_lines", 32'(lines_filled_out), 32'd3);
        chk("hold_frame_done", 32'(frame_done_out), 32'd0);
        step(1'b1, 1, 0);
        chk("idle2_wr_en", 32'(wr_en_out), 32'd0);

        // Frame 2 with random gaps; first line lands on bank 2
        wen_cnt = 0;
        run_frame(1'b1);
        chk("f2_wr_en_count", 32'(wen_cnt), 32'd48);
        chk("f2_end_bidx", 32'(bidx), 32'd0);

        // Frame 3: three lines, half of row 3, then a restart
        exp_lines = 0;
        exp_wv = 0;
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < 8; h++) send_pix(h, v);
        end
        for (int h = 0; h < 4; h++) send_pix(h, 3);
        step(1'b1, 0, 0);
        exp_lines = 0;
        exp_wv = 0;
        chk("rs_sync_err", 32'(sync_err_out), 32'd1);
        chk("rs_wr_en", 32'(wr_en_out), 32'd1);
        chk("rs_wr_bank", 32'(wr_bank_out), 32'h8);
        chk("rs_lines", 32'(lines_filled_out), 32'd0);
        chk("rs_wv", 32'(window_valid_out), 32'd0);
        chk("rs_rd_sel", 32'(rd_sel_out), 32'(exp_rd(3)));
        chk("rs_line_done", 32'(line_done_out), 32'd0);
        step(1'b0, 0, 0);
        chk("rs_sync_once", 32'(sync_err_out), 32'd0);

        // Out-of-range pixels: not written, sticky error
        step(1'b1, 8, 0);
        chk("oor_h_wr_en", 32'(wr_en_out), 32'd0);
        chk("oor_h_range_err", 32'(range_err_out), 32'd1);
        step(1'b1, 0, 6);
        chk("oor_v_wr_en", 32'(wr_en_out), 32'd0);
        exp_rerr = 1;

        // Finish the restarted frame on the unrotated bank
        for (int h = 1; h < 8; h++) send_pix(h, 0);
        for (int v = 1; v < 6; v++) begin
            for (int h = 0; h < 8; h++) send_pix(h, v);
        end

        // Next frame still shows the sticky error
        run_frame(1'b0);

        // Reset mid-line drops the pixel and clears everything
        rst_in = 1'b1;
        step(1'b1, 2, 0);
        chk("rst2_wr_en", 32'(wr_en_out), 32'd0);
        chk("rst2_range_err", 32'(range_err_out), 32'd0);
        chk("rst2_wr_bank", 32'(wr_bank_out), 32'h1);
        chk("rst2_rd_sel", 32'(rd_sel_out), 32'h1B);
        chk("rst2_wv", 32'(window_valid_out), 32'd0);
        rst_in = 1'b0;
        step(1'b1, 0, 0);
        chk("post_rst_wr_en", 32'(wr_en_out), 32'd1);
        chk("post_rst_bank", 32'(wr_bank_out), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_sequencer.md
# line_buffer_sequencer

Control sequencer for the 4-bank rotating line buffer in the camera-to-filter path. Consumes the raw pixel stream coordinates (hcount, vcount, valid) and produces per-pixel bank write strobes and addresses, bank rotation, and the three read-tap bank selects. Also provides frame-aligned fill status and the row index of the centre tap, so the 3x3 convolution stage knows when a full window is present. Owns no pixel storage; the BRAM banks and data muxing sit beside it.

## Interface
Parameters:
- H_ACTIVE, 320, pixels per line; accepted hcount range 0..H_ACTIVE-1
- V_ACTIVE, 240, lines per frame; accepted vcount range 0..V_ACTIVE-1

Ports:
- clk_in  input  1  system clock; the only clock
- rst_in  input  1  synchronous, active-high reset
- hcount_in  input  11  column of incoming pixel
- vcount_in  input  10  row of incoming pixel
- data_valid_in  input  1  incoming pixel valid
- wr_en_out  output  1  write strobe to the selected bank
- wr_bank_out  output  4  one-hot write bank select; bit k selects bank k
- wr_addr_out  output  9  bank write address, hcount_in[8:0]
- rd_sel_out  output  3x2 (packed [2:0][1:0])  bank index per tap; [0] newest complete line, [2] oldest
- lines_filled_out  output  2  complete lines in current frame, saturating at 3
- window_valid_out  output  1  three complete lines of the current frame are buffered
- center_row_out  output  10  vcount of the line on tap [1]
- line_done_out  output  1  one-cycle pulse: a line just completed
- frame_done_out  output  1  one-cycle pulse: line V_ACTIVE-1 just completed
- sync_err_out  output  1  one-cycle pulse: frame restart seen mid-frame
- range_err_out  output  1  sticky: valid pixel outside active area seen; cleared only by reset

## Operation
- Internal write index wr_idx (2 bits, mod 4). wr_bank_out = one-hot(wr_idx). rd_sel_out[i] = wr_idx-1-i mod 4.
- State machine: IDLE, FILL, STREAM.
  - IDLE: ignore all pixels except a frame start (valid, hcount_in=0, vcount_in=0). On frame start: accept it, lines_filled=0, window_valid=0, go to FILL.
  - FILL: accept in-range pixels; each line end increments lines_filled; the third line end sets window_valid and moves to STREAM.
  - STREAM: accept in-range pixels; window_valid stays 1.
  - In FILL/STREAM, a line end with vcount_in=V_ACTIVE-1 pulses frame_done_out and returns to IDLE. window_valid and lines_filled hold their values in IDLE until the next frame start, so the last window stays readable.
- Accepted pixel: wr_en_out=1, wr_addr_out=hcount_in[8:0], wr_bank_out=current bank.
- Line end: accepted pixel with hcount_in=H_ACTIVE-1.
  - wr_idx increments and line_done_out pulses.
  - center_row_out = vcount_in-1, saturating at 0.
  - Bank rotation is continuous across frames; wr_idx is never reset except by rst_in.
- Out of range: valid pixel with hcount_in>=H_ACTIVE or vcount_in>=V_ACTIVE, in any state.
  - Not written; range_err_out is set.
- Frame restart: frame start seen in FILL or STREAM.
  - Pulse sync_err_out.
  - Reset lines_filled and window_valid, stay in or enter FILL.
  - Accept the pixel into the current bank; no rotation, so the partial line is overwritten.
- data_valid_in=0: wr_en_out=0; no other state change.

## Timing
- All outputs are registered. Accepted pixel at edge N gives wr_en_out, wr_addr_out and wr_bank_out at cycle N+1.
- Line end at edge N:
  - At N+1: wr_en_out for the last pixel on the old bank, plus line_done_out, updated rd_sel_out, lines_filled_out, center_row_out, and window_valid_out where applicable.
  - The pixel at edge N+1 is written to the new bank.
- frame_done_out coincides with line_done_out.
- Reset values:
  - wr_idx=0: wr_bank_out=4'b0001, rd_sel_out={1,2,3} for taps [2],[1],[0].
  - wr_en_out=0, wr_addr_out=0, lines_filled_out=0, window_valid_out=0, center_row_out=0.
  - All pulses 0, range_err_out=0, state IDLE.
- Reset asserted mid-line overrides everything on that edge; the pixel on that edge is dropped.
- Back-to-back valid pixels at full clock rate are supported; there is no backpressure.

## Test plan
Bench parameters: H_ACTIVE=8, V_ACTIVE=6.
- Reset, then one full frame at 1 pixel/clock.
  - Expect wr_bank_out to cycle 0001, 0010, 0100, 1000, 0001, 0010.
  - Expect 6 line_done pulses.
  - window_valid_out rises with the 3rd line_done, with center_row_out=1 and rd_sel_out={1,2,3}→{0,1,2} at that point (tap[0]=2).
  - frame_done_out fires with the 6th line_done.
- Pixels with random valid gaps.
  - wr_addr_out equals the accepted hcount.
  - wr_en_out count is 48 per frame.
  - Bank rotation is identical to the gapless case.
- Pixels at (3,2) before any frame start: no wr_en_out, state stays IDLE. A later (0,0) is written to bank 0.
- Frame start injected at (0,0) during row 3.
  - sync_err_out pulses once.
  - lines_filled_out=0 and window_valid_out=0.
  - No bank rotation.
- Valid pixel at hcount=8 or vcount=6: no write, range_err_out=1 and held through the next frame. Reset clears it.
- Two consecutive frames.
  - Second frame's first line writes bank 2 (wr_idx continues from 6 mod 4).
  - window_valid_out holds 1 between frames and drops on the second frame start.
